// File: rtl/keypad_scanner.sv
// keypad_scanner
// Matrix-keypad scanner for the dosing unit operator keypad.
// Drives one column at a time for DWELL clocks and samples the synchronised
// rows at the end of each dwell. The lowest active code seen in a full frame
// is debounced over DEBOUNCE frames. Each accepted press is reported once
// through a valid/ack handshake.
//
// Ports:
//   clk       system clock
//   rst       asynchronous active-high reset
//   filas     raw row lines, active-high, asynchronous to clk
//   columnas  one-hot column drive
//   key_code  accepted key code, row*NCOLS+col
//   key_valid key_code valid, held until key_ack
//   key_ack   consumer accepts key_code while key_valid=1
//   key_down  high while a debounced key is held
//
// Optional macro KEYPAD_REPEAT_EN: while a key is held, key_valid re-asserts
// every REPEAT_FRAMES frames if the previous report has been acknowledged.
//
// FSM states:
//   state       | meaning
//   IDLE        | no key held; waiting for a key frame (blocked while key_valid)
//   DEB_PRESS   | candidate key seen, counting identical frames
//   HELD        | key accepted and held down
//   DEB_RELEASE | empty frames seen, counting toward release
module keypad_scanner #(
    parameter int NCOLS         = 4,
    parameter int NROWS         = 4,
    parameter int DWELL         = 1000,
    parameter int DEBOUNCE      = 4,
    parameter int REPEAT_FRAMES = 250
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [NROWS-1:0]                 filas,
    output logic [NCOLS-1:0]                 columnas,
    output logic [$clog2(NROWS*NCOLS)-1:0]   key_code,
    output logic                             key_valid,
    input  logic                             key_ack,
    output logic                             key_down
);
    localparam int CW  = $clog2(NROWS*NCOLS);
    localparam int CIW = $clog2(NCOLS);
    localparam int DW  = $clog2(DWELL);
    localparam int BW  = $clog2(DEBOUNCE+1);

    if (NCOLS < 2 || NROWS < 1 || DWELL < 3 || DEBOUNCE < 1 || REPEAT_FRAMES < 1) begin : g_bad_params
        $error("keypad_scanner: illegal parameter value");
    end

    typedef enum logic [1:0] {IDLE, DEB_PRESS, HELD, DEB_RELEASE} state_t;

    logic [NROWS-1:0] sync1, sync2;
    logic [DW-1:0]    dwell_cnt;
    logic [CIW-1:0]   col_idx;
    logic             acc_hit;
    logic [CW-1:0]    acc_code;
    logic             sample_en, frame_end;
    logic             samp_hit, res_hit;
    logic [CW-1:0]    samp_code, res_code;

    state_t           state, state_nxt;
    logic [CW-1:0]    cand, cand_nxt;
    logic [BW-1:0]    cnt, cnt_nxt;
    logic [CW-1:0]    key_code_nxt;
    logic             key_valid_nxt, key_down_nxt;
    logic             accept;

    assign sample_en = (dwell_cnt == DW'(DWELL-1));
    assign frame_end = sample_en && (col_idx == CIW'(NCOLS-1));
    assign columnas  = NCOLS'(1) << col_idx;

    // Lowest active row of the current column gives the lowest code for it.
    always_comb begin
        samp_hit  = 1'b0;
        samp_code = '0;
        for (int r = NROWS-1; r >= 0; r--) begin
            if (sync2[r]) begin
                samp_hit  = 1'b1;
                samp_code = CW'(r*NCOLS + int'(col_idx));
            end
        end
    end

    // Running minimum over the frame, including the sample taken this cycle.
    always_comb begin
        res_hit  = acc_hit | samp_hit;
        res_code = samp_code;
        if (acc_hit && (!samp_hit || acc_code < samp_code)) begin
            res_code = acc_code;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1     <= '0;
            sync2     <= '0;
            dwell_cnt <= '0;
            col_idx   <= '0;
            acc_hit   <= 1'b0;
            acc_code  <= '0;
        end else begin
            sync1 <= filas;
            sync2 <= sync1;
            if (sample_en) begin
                dwell_cnt <= '0;
                if (col_idx == CIW'(NCOLS-1)) begin
                    col_idx <= '0;
                end else begin
                    col_idx <= col_idx + 1'b1;
                end
                if (frame_end) begin
                    acc_hit  <= 1'b0;
                    acc_code <= '0;
                end else begin
                    acc_hit  <= res_hit;
                    acc_code <= res_code;
                end
            end else begin
                dwell_cnt <= dwell_cnt + 1'b1;
            end
        end
    end

`ifdef KEYPAD_REPEAT_EN
    localparam int RW = $clog2(REPEAT_FRAMES+1);
    logic [RW-1:0] rep_cnt, rep_nxt;
`endif

    always_comb begin
        state_nxt     = state;
        cand_nxt      = cand;
        cnt_nxt       = cnt;
        key_code_nxt  = key_code;
        key_valid_nxt = key_valid;
        key_down_nxt  = key_down;
        accept        = 1'b0;

        if (key_valid && key_ack) begin
            key_valid_nxt = 1'b0;
        end

        if (frame_end) begin
            case (state)
                IDLE: begin
                    // An unacknowledged key blocks new presses from even starting.
                    if (res_hit && !key_valid) begin
                        cand_nxt = res_code;
                        cnt_nxt  = BW'(1);
                        if (DEBOUNCE == 1) begin
                            accept = 1'b1;
                        end else begin
                            state_nxt = DEB_PRESS;
                        end
                    end
                end
                DEB_PRESS: begin
                    if (!res_hit) begin
                        state_nxt = IDLE;
                    end else if (res_code == cand) begin
                        if (cnt == BW'(DEBOUNCE-1)) begin
                            accept = 1'b1;
                        end else begin
                            cnt_nxt = cnt + 1'b1;
                        end
                    end else begin
                        cand_nxt = res_code;
                        cnt_nxt  = BW'(1);
                    end
                end
                HELD: begin
                    if (!res_hit) begin
                        cnt_nxt = BW'(1);
                        if (DEBOUNCE == 1) begin
                            state_nxt    = IDLE;
                            key_down_nxt = 1'b0;
                        end else begin
                            state_nxt = DEB_RELEASE;
                        end
                    end
                end
                DEB_RELEASE: begin
                    if (res_hit) begin
                        state_nxt = HELD;
                    end else if (cnt == BW'(DEBOUNCE-1)) begin
                        state_nxt    = IDLE;
                        key_down_nxt = 1'b0;
                    end else begin
                        cnt_nxt = cnt + 1'b1;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end

        if (accept) begin
            if (key_valid) begin
                state_nxt = IDLE;
            end else begin
                key_code_nxt  = cand_nxt;
                key_valid_nxt = 1'b1;
                key_down_nxt  = 1'b1;
                state_nxt     = HELD;
            end
        end

`ifdef KEYPAD_REPEAT_EN
        rep_nxt = rep_cnt;
        if (frame_end && state == HELD && state_nxt == HELD) begin
            if (rep_cnt == '0) begin
                rep_nxt = RW'(REPEAT_FRAMES-1);
                if (!key_valid) begin
                    key_valid_nxt = 1'b1;
                end
            end else begin
                rep_nxt = rep_cnt - 1'b1;
            end
        end
        if (state != HELD && state_nxt == HELD) begin
            rep_nxt = RW'(REPEAT_FRAMES-1);
        end
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cand      <= '0;
            cnt       <= '0;
            key_code  <= '0;
            key_valid <= 1'b0;
            key_down  <= 1'b0;
`ifdef KEYPAD_REPEAT_EN
            rep_cnt   <= '0;
`endif
        end else begin
            state     <= state_nxt;
            cand      <= cand_nxt;
            cnt       <= cnt_nxt;
            key_code  <= key_code_nxt;
            key_valid <= key_valid_nxt;
            key_down  <= key_down_nxt;
`ifdef KEYPAD_REPEAT_EN
            rep_cnt   <= rep_nxt;
`endif
        end
    end

endmodule
